inst_sram_axi_bridge: RTL and testbench
=======================================

# inst_sram_axi_bridge

Responder side of the core's instruction-fetch SRAM-style port (addr/readen → rdata/valid). It accepts one fetch request at a time from the fetch stage and turns it into a single-beat AXI4 read on the instruction bus. The data returns to the fetch stage as a one-cycle `inst_sram_valid` pulse. It sits between the fetch stage and the AXI interconnect and keeps at most one transaction outstanding.

## Interface
- `AXI_ID`, default 4'h0: constant value driven on `arid`.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inst_sram_addr`  in  32  fetch byte address; sampled only on the accept cycle.
- `inst_sram_readen`  in  1  request strobe; meaningful only when the bridge can accept.
- `inst_sram_rdata`  out  32  returned instruction word; held until the next response.
- `inst_sram_valid`  out  1  one-cycle pulse: `rdata` is valid for the last accepted request.
- `inst_sram_err`  out  1  pulses with `valid` on a bus error (see Configuration).
- `arid`  out  4  = `AXI_ID`.
- `araddr`  out  32  captured address with [1:0] forced to 0.
- `arlen`  out  8  = 0.
- `arsize`  out  3  = 3'b010.
- `arburst`  out  2  = 2'b01.
- `arvalid`  out  1  AXI read-address valid.
- `arready`  in  1  AXI read-address ready.
- `rdata`  in  32  AXI read data.
- `rresp`  in  2  AXI read response.
- `rlast`  in  1  ignored (single beat).
- `rvalid`  in  1  AXI read-data valid.
- `rready`  out  1  AXI read-data ready.

## Operation
- FSM states: IDLE, AR, R, RESP.
- Accept condition: `inst_sram_readen` = 1 while in IDLE or RESP. This mirrors the initiator rule "new command only when valid or not busy".
- `inst_sram_readen` and `inst_sram_addr` in AR and R are ignored. The fetch stage keeps `readen` high while waiting; this must not create requests or change `araddr`.
- IDLE: on accept, capture the address and go to AR.
- AR: `arvalid` = 1 and `araddr` stable. On `arvalid && arready`, go to R.
- R: `rready` = 1. On `rvalid && rready`, capture `rdata` (and the error flag) and go to RESP.
- RESP: `inst_sram_valid` = 1 for exactly this cycle. On accept, go to AR; otherwise go to IDLE.
- A request is never dropped. Every accepted request produces exactly one `valid` pulse.
- Reset values: state IDLE; `arvalid`, `rready`, `inst_sram_valid`, `inst_sram_err` = 0; `inst_sram_rdata` = 0; `araddr` = 0.
- Reset mid-transaction (AR or R) returns to IDLE immediately. `arvalid` drops and no `valid` pulse is produced; the interconnect is reset together with the core.
- Address bits [1:0] are discarded. Misaligned fetches are filtered upstream (`readen` low).

## Timing
- Accept at cycle T puts `arvalid` = 1 from T+1.
- AR handshake at cycle A puts `rready` = 1 from A+1.
- R handshake at cycle D gives `inst_sram_valid` = 1 and new `inst_sram_rdata` at D+1.
- Minimum latency: accept at T, `arready` at T+1, `rvalid` at T+2, `valid` at T+3.
- Back-to-back: an accept in the RESP cycle puts `arvalid` high the next cycle, with no idle cycle between transactions.
- `arvalid` stays high until handshake; `araddr` is constant while `arvalid` is high.
- `inst_sram_rdata` is registered and stable from the `valid` cycle until the next R handshake is captured.

## Configuration
- `IBRIDGE_RRESP_CHECK_EN` defined:
  - At R capture, `rresp` ≠ 2'b00 forces `inst_sram_rdata` = 32'h0000_0000.
  - `inst_sram_err` pulses in the same cycle as `inst_sram_valid`.
- `IBRIDGE_RRESP_CHECK_EN` undefined:
  - `rresp` is ignored and `rdata` passes through unchanged.
  - `inst_sram_err` is tied to 0.

## Test plan
- Single fetch: `readen`=1, addr 32'hBFC0_0000 in IDLE; `arready`=1 and `rvalid`=1 immediately with `rdata`=32'h3C08_0001 → `araddr`=BFC0_0000; `valid` pulses 3 cycles after accept with `rdata`=3C08_0001.
- Back-to-back: `readen` held high with addr BFC0_0004 during the RESP cycle → `arvalid` high next cycle with `araddr`=BFC0_0004, and exactly two `valid` pulses total.
- Backpressure and busy filtering:
  - Stimulus: hold `arready`=0 for 5 cycles while the fetch stage drives `readen`=1 with addr 32'h0000_1234.
  - Required: `araddr` stays at the original address and no second transaction is issued.
- `rvalid` delayed 10 cycles → `rready` stays high the whole time; `valid` comes 1 cycle after the handshake; `rdata` is stable afterwards until the next response.
- `rresp`=2'b10 with `rdata`=DEAD_BEEF:
  - With the macro: `rdata` out 0 and `err`=1.
  - Without the macro: `rdata` out DEAD_BEEF and `err`=0.
- Reset asserted in R state → next cycle IDLE with `arvalid`, `rready` and `valid` all 0. A following `readen` request completes normally.

Source files
------------

// File: rtl/inst_sram_axi_bridge.sv
// inst_sram_axi_bridge: single-outstanding bridge from SRAM-style fetch port to single-beat AXI4 reads.
// Optional IBRIDGE_RRESP_CHECK_EN zeroes data and flags inst_sram_err on a non-OKAY rresp.
module inst_sram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_sram_addr,
  input  logic        inst_sram_readen,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_sram_valid,
  output logic        inst_sram_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;
  state_t state, state_nxt;
  logic [29:0] addr_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        r_hs;
  logic        resp_bad;
  logic        unused_ok;
  assign accept    = inst_sram_readen && (state == IDLE || state == RESP);
  assign r_hs      = rvalid && rready;
  assign arid      = AXI_ID;
  assign araddr    = {addr_q, 2'b00};
  assign arlen     = 8'd0;
  assign arsize    = 3'b010;
  assign arburst   = 2'b01;
  assign arvalid   = state == AR;
  assign rready    = state == R;
  assign inst_sram_valid = state == RESP;
  assign inst_sram_rdata = rdata_q;
  assign unused_ok = ^{rlast, rresp, inst_sram_addr[1:0]};
`ifdef IBRIDGE_RRESP_CHECK_EN
  assign resp_bad      = rresp != 2'b00;
  assign inst_sram_err = inst_sram_valid && err_q;
`else
  assign resp_bad      = 1'b0;
  assign inst_sram_err = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? AR : IDLE;
      AR:      state_nxt = arready ? R : AR;
      R:       state_nxt = r_hs ? RESP : R;
      default: state_nxt = accept ? AR : IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) addr_q <= inst_sram_addr[31:2];
      if (r_hs) begin
        rdata_q <= resp_bad ? 32'h0 : rdata;
        err_q   <= resp_bad;
      end
    end
  end
endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// tb_inst_sram_axi_bridge: directed self-checking bench for inst_sram_axi_bridge.
module tb_inst_sram_axi_bridge;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst_sram_addr = '0;
  logic        inst_sram_readen = 1'b0;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_valid;
  logic        inst_sram_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b1;
  logic        rvalid = 1'b0;
  logic        rready;
  int n_cmp = 0;
  int n_err = 0;
  int n_valid = 0;
  inst_sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_addr(inst_sram_addr), .inst_sram_readen(inst_sram_readen),
    .inst_sram_rdata(inst_sram_rdata), .inst_sram_valid(inst_sram_valid),
    .inst_sram_err(inst_sram_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (inst_sram_valid) n_valid++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step();
    step();
    chk("rst_arvalid", {31'd0, arvalid}, 0);
    chk("rst_rready", {31'd0, rready}, 0);
    chk("rst_valid", {31'd0, inst_sram_valid}, 0);
    chk("rst_err", {31'd0, inst_sram_err}, 0);
    chk("rst_rdata", inst_sram_rdata, 0);
    chk("rst_araddr", araddr, 0);
    chk("const_ar", {arid, arlen, arsize, arburst, 15'd0}, {4'h0, 8'd0, 3'b010, 2'b01, 15'd0});
    reset = 1'b0;
    n_valid = 0;
    // single fetch with immediate AXI responses
    inst_sram_readen = 1'b1; inst_sram_addr = 32'hBFC0_0000;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h3C08_0001;
    step();
    inst_sram_readen = 1'b0;
    chk("t1_arvalid", {31'd0, arvalid}, 1);
    chk("t1_araddr", araddr, 32'hBFC0_0000);
    step();
    chk("t1_rready", {31'd0, rready}, 1);
    chk("t1_valid_early", {31'd0, inst_sram_valid}, 0);
    step();
    chk("t1_valid", {31'd0, inst_sram_valid}, 1);
    chk("t1_rdata", inst_sram_rdata, 32'h3C08_0001);
    // back-to-back accept in RESP
    inst_sram_readen = 1'b1; inst_sram_addr = 32'hBFC0_0004; rdata = 32'h2408_0002;
    step();
    inst_sram_readen = 1'b0;
    chk("t2_arvalid", {31'd0, arvalid}, 1);
    chk("t2_araddr", araddr, 32'hBFC0_0004);
    chk("t2_valid_gap", {31'd0, inst_sram_valid}, 0);
    step();
    step();
    chk("t2_valid", {31'd0, inst_sram_valid}, 1);
    chk("t2_rdata", inst_sram_rdata, 32'h2408_0002);
    step();
    step();
    chk("t2_pulses", n_valid, 2);
    chk("t2_idle_arvalid", {31'd0, arvalid}, 0);
    // arready backpressure, readen held high while busy
    arready = 1'b0; rvalid = 1'b0;
    inst_sram_readen = 1'b1; inst_sram_addr = 32'h0000_1234;
    step();
    inst_sram_addr = 32'h0000_5678;
    for (int i = 0; i < 5; i++) begin
      chk("t3_arvalid", {31'd0, arvalid}, 1);
      chk("t3_araddr", araddr, 32'h0000_1234);
      step();
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    // rvalid held off for 10 cycles
    for (int i = 0; i < 10; i++) begin
      chk("t4_rready", {31'd0, rready}, 1);
      chk("t4_arvalid", {31'd0, arvalid}, 0);
      step();
    end
    chk("t4_araddr", araddr, 32'h0000_1234);
    inst_sram_readen = 1'b0; rvalid = 1'b1; rdata = 32'h1111_2222;
    step();
    rvalid = 1'b0;
    chk("t4_valid", {31'd0, inst_sram_valid}, 1);
    chk("t4_rdata", inst_sram_rdata, 32'h1111_2222);
    rdata = 32'h9999_9999;
    step();
    chk("t4_valid_end", {31'd0, inst_sram_valid}, 0);
    chk("t4_rdata_hold", inst_sram_rdata, 32'h1111_2222);
    chk("t4_no_second", {31'd0, arvalid}, 0);
    chk("t4_pulses", n_valid, 3);
    // error response
    inst_sram_readen = 1'b1; inst_sram_addr = 32'h0000_0100;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
    step();
    inst_sram_readen = 1'b0;
    step();
    step();
    chk("t5_valid", {31'd0, inst_sram_valid}, 1);
`ifdef IBRIDGE_RRESP_CHECK_EN
    chk("t5_rdata", inst_sram_rdata, 32'h0);
    chk("t5_err", {31'd0, inst_sram_err}, 1);
`else
    chk("t5_rdata", inst_sram_rdata, 32'hDEAD_BEEF);
    chk("t5_err", {31'd0, inst_sram_err}, 0);
`endif
    rvalid = 1'b0; rresp = 2'b00;
    step();
    chk("t5_err_end", {31'd0, inst_sram_err}, 0);
    // reset while in R
    inst_sram_readen = 1'b1; inst_sram_addr = 32'h0000_0200;
    step();
    inst_sram_readen = 1'b0;
    step();
    chk("t6_in_r", {31'd0, rready}, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_arvalid", {31'd0, arvalid}, 0);
    chk("t6_rready", {31'd0, rready}, 0);
    chk("t6_valid", {31'd0, inst_sram_valid}, 0);
    inst_sram_readen = 1'b1; inst_sram_addr = 32'h0000_0302;
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    step();
    inst_sram_readen = 1'b0;
    chk("t6_araddr", araddr, 32'h0000_0300);
    step();
    step();
    chk("t6_valid2", {31'd0, inst_sram_valid}, 1);
    chk("t6_rdata", inst_sram_rdata, 32'hCAFE_F00D);
    rvalid = 1'b0;
    step();
    chk("t6_pulses", n_valid, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
